// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the open-drain ps2c/ps2d pair.
// Define PS2_HOST_TX_TIMEOUT_EN to add a watchdog that aborts a frame when the device stops clocking.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned FILTER_LEN     = 8
`ifdef PS2_HOST_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_ack_err,
    output logic       tx_timeout_tick
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRts   = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StStop  = 3'd4;
    localparam logic [2:0] StAck   = 3'd5;
    localparam logic [2:0] StWait  = 3'd6;

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

    logic [2:0]            stateQ, stateD;
    logic [8:0]            frameQ, frameD;
    logic [3:0]            nQ, nD;
    logic [InhW-1:0]       inhQ, inhD;
    logic                  ackQ, ackD;
    logic [FILTER_LEN-1:0] filtQ;
    logic                  fclkQ, fclkD;
    logic                  fallTick;
    logic [1:0]            dSyncQ;
    logic                  ps2dS;
    logic                  doneCond;
    logic                  wdExpired;
    logic                  driveC, driveD;

    // Filtered clock only moves once the whole shift register agrees.
    always_comb begin
        fclkD = fclkQ;
        if (&filtQ) begin
            fclkD = 1'b1;
        end else if (~|filtQ) begin
            fclkD = 1'b0;
        end
        fallTick = fclkQ & ~fclkD;
    end

    assign ps2dS    = dSyncQ[1];
    assign doneCond = (stateQ == StWait) && fclkQ && ps2dS;

    always_comb begin
        stateD       = stateQ;
        frameD       = frameQ;
        nD           = nQ;
        inhD         = inhQ;
        ackD         = ackQ;
        tx_done_tick = 1'b0;
        case (stateQ)
            StIdle: begin
                if (tx_wr) begin
                    frameD = {~^tx_data, tx_data};
                    nD     = 4'd0;
                    inhD   = '0;
                    stateD = StRts;
                end
            end
            StRts: begin
                if (inhQ == InhLast) begin
                    stateD = StStart;
                end else begin
                    inhD = inhQ + 1'b1;
                end
            end
            StStart: begin
                if (fallTick) begin
                    stateD = StData;
                end
            end
            StData: begin
                if (fallTick) begin
                    frameD = {1'b0, frameQ[8:1]};
                    if (nQ == 4'd8) begin
                        stateD = StStop;
                    end else begin
                        nD = nQ + 4'd1;
                    end
                end
            end
            StStop: begin
                if (fallTick) begin
                    stateD = StAck;
                end
            end
            StAck: begin
                if (fallTick) begin
                    ackD   = ps2dS;
                    stateD = StWait;
                end
            end
            StWait: begin
                if (doneCond) begin
                    tx_done_tick = 1'b1;
                    stateD       = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
        if (wdExpired) begin
            stateD = StIdle;
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES);

    logic [WdW-1:0] wdQ, wdD;
    logic           wdActive;

    // Counter is held at zero outside the device-clocked states, so START always begins at zero.
    always_comb begin
        wdActive = (stateQ >= StStart) && (stateQ <= StWait);
        wdD      = '0;
        if (wdActive && !fallTick) begin
            wdD = wdQ + 1'b1;
        end
        wdExpired = wdActive && (wdQ == WdLimit) && !doneCond;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdQ <= '0;
        end else begin
            wdQ <= wdD;
        end
    end

    assign tx_timeout_tick = wdExpired;
`else
    assign wdExpired       = 1'b0;
    assign tx_timeout_tick = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            frameQ <= '0;
            nQ     <= '0;
            inhQ   <= '0;
            ackQ   <= 1'b0;
            filtQ  <= '1;
            fclkQ  <= 1'b1;
            dSyncQ <= 2'b11;
        end else begin
            stateQ <= stateD;
            frameQ <= frameD;
            nQ     <= nD;
            inhQ   <= inhD;
            ackQ   <= ackD;
            filtQ  <= {ps2c, filtQ[FILTER_LEN-1:1]};
            fclkQ  <= fclkD;
            dSyncQ <= {dSyncQ[0], ps2d};
        end
    end

    assign tx_idle    = (stateQ == StIdle);
    assign tx_ack_err = tx_done_tick & ackQ;

    assign driveC = (stateQ == StRts);
    assign driveD = (stateQ == StStart) || ((stateQ == StData) && !frameQ[0]);

    // Open drain: only ever pull low; reset releases both lines without waiting for a clock.
    assign ps2c = (driveC && !reset) ? 1'b0 : 1'bz;
    assign ps2d = (driveD && !reset) ? 1'b0 : 1'bz;

endmodule
